// File: rtl/bus_waitstate_ctrl_pkg.sv
// rtl/bus_waitstate_ctrl_pkg.sv - GBA region map, bus widths and WAITCNT wait-state tables
package bus_waitstate_ctrl_pkg;

  typedef enum logic [3:0] {
    REG_BIOS, REG_EWRAM, REG_IWRAM, REG_IO, REG_PAL, REG_VRAM, REG_OAM,
    REG_WS0, REG_WS1, REG_WS2, REG_SRAM, REG_UNMAPPED
  } region_t;

  typedef enum logic [1:0] { BUS_8, BUS_16, BUS_32 } bus_width_t;

  // Region base values of addr[27:24]; each Game Pak wait-state window spans two of them
  localparam logic [3:0] BASE_BIOS  = 4'h0;
  localparam logic [3:0] BASE_EWRAM = 4'h2;
  localparam logic [3:0] BASE_IWRAM = 4'h3;
  localparam logic [3:0] BASE_IO    = 4'h4;
  localparam logic [3:0] BASE_PAL   = 4'h5;
  localparam logic [3:0] BASE_VRAM  = 4'h6;
  localparam logic [3:0] BASE_OAM   = 4'h7;
  localparam logic [3:0] BASE_WS0   = 4'h8;
  localparam logic [3:0] BASE_WS1   = 4'hA;
  localparam logic [3:0] BASE_WS2   = 4'hC;
  localparam logic [3:0] BASE_SRAM  = 4'hE;

  function automatic logic [3:0] rom_n_wait(input logic [1:0] sel);
    case (sel)
      2'd0:    return 4'd4;
      2'd1:    return 4'd3;
      2'd2:    return 4'd2;
      default: return 4'd8;
    endcase
  endfunction

  function automatic logic [3:0] rom_s_wait(input region_t region, input logic fast);
    if (fast) return 4'd1;
    case (region)
      REG_WS0: return 4'd2;
      REG_WS1: return 4'd4;
      default: return 4'd8;
    endcase
  endfunction

  function automatic logic [3:0] sram_wait(input logic [1:0] sel);
    return rom_n_wait(sel);
  endfunction

  function automatic logic is_gamepak(input region_t region);
    return region inside {REG_WS0, REG_WS1, REG_WS2, REG_SRAM};
  endfunction

endpackage

// File: rtl/bus_region_decode.sv
// rtl/bus_region_decode.sv - combinational address-nibble to region, bus width and N/S waits
module bus_region_decode
  import bus_waitstate_ctrl_pkg::*;
#(
  parameter int EWRAM_WAIT = 2
) (
  input  logic [3:0]  region_sel,
  input  logic [10:0] waitcnt,
  output region_t     region,
  output bus_width_t  width,
  output logic [3:0]  n_wait,
  output logic [3:0]  s_wait
);

  localparam logic [3:0] EWRAM_W = 4'(EWRAM_WAIT);

  always_comb begin
    region = REG_UNMAPPED;
    width  = BUS_32;
    n_wait = 4'd0;
    s_wait = 4'd0;
    case (region_sel)
      BASE_BIOS:  region = REG_BIOS;
      BASE_EWRAM: begin
        region = REG_EWRAM;
        width  = BUS_16;
        n_wait = EWRAM_W;
        s_wait = EWRAM_W;
      end
      BASE_IWRAM: region = REG_IWRAM;
      BASE_IO:    region = REG_IO;
      BASE_OAM:   region = REG_OAM;
      BASE_PAL: begin
        region = REG_PAL;
        width  = BUS_16;
      end
      BASE_VRAM: begin
        region = REG_VRAM;
        width  = BUS_16;
      end
      BASE_WS0, BASE_WS0 + 4'h1: begin
        region = REG_WS0;
        width  = BUS_16;
        n_wait = rom_n_wait(waitcnt[3:2]);
        s_wait = rom_s_wait(REG_WS0, waitcnt[4]);
      end
      BASE_WS1, BASE_WS1 + 4'h1: begin
        region = REG_WS1;
        width  = BUS_16;
        n_wait = rom_n_wait(waitcnt[6:5]);
        s_wait = rom_s_wait(REG_WS1, waitcnt[7]);
      end
      BASE_WS2, BASE_WS2 + 4'h1: begin
        region = REG_WS2;
        width  = BUS_16;
        n_wait = rom_n_wait(waitcnt[9:8]);
        s_wait = rom_s_wait(REG_WS2, waitcnt[10]);
      end
      BASE_SRAM: begin
        region = REG_SRAM;
        width  = BUS_8;
        n_wait = sram_wait(waitcnt[1:0]);
        s_wait = sram_wait(waitcnt[1:0]);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/bus_waitstate_ctrl.sv
// rtl/bus_waitstate_ctrl.sv - CPU bus to memory port bridge with GBA region wait-state timing
module bus_waitstate_ctrl
  import bus_waitstate_ctrl_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int EWRAM_WAIT = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic              cpu_read_en,
  input  logic              cpu_write_en,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic              cpu_byte,
  input  logic              cpu_instruction_fetch,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ready,
  output logic              access_seq,
  input  logic [15:0]       waitcnt,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] { S_IDLE, S_XFER1, S_XFER2, S_DONE } state_t;

  state_t            state, state_n;
  logic [3:0]        wait_cnt;
  logic [ADDR_W-1:0] acc_addr;
  logic              acc_write, acc_byte, acc_seq;
  region_t           acc_region;
  bus_width_t        acc_width;
  logic              lo_cap, prev_valid;
  logic [15:0]       lo_half;
  logic              load_first, load_second, seq_hit;

  region_t           dec_region;
  bus_width_t        dec_width;
  logic [3:0]        dec_n, dec_s;
  logic [3:0]        byte_lane, first_be;
  logic [ADDR_W-1:0] first_addr;
  logic [DATA_W-1:0] first_wdata;

  logic unused_inputs;
  assign unused_inputs = ^{waitcnt[15:11], cpu_instruction_fetch};

  // The request is only trusted while idle; afterwards the latched address drives the decode
  bus_region_decode #(.EWRAM_WAIT(EWRAM_WAIT)) u_decode (
    .region_sel (state == S_IDLE ? cpu_addr[27:24] : acc_addr[27:24]),
    .waitcnt    (waitcnt[10:0]),
    .region     (dec_region),
    .width      (dec_width),
    .n_wait     (dec_n),
    .s_wait     (dec_s)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n     = state;
    load_first  = 1'b0;
    load_second = 1'b0;
    case (state)
      S_IDLE: begin
        if (cpu_read_en ^ cpu_write_en) begin
          state_n    = S_XFER1;
          load_first = 1'b1;
        end
      end
      S_XFER1: begin
        if (wait_cnt == 4'd0) begin
          if (acc_width == BUS_16 && !acc_byte) begin
            state_n     = S_XFER2;
            load_second = 1'b1;
          end else begin
            state_n = S_DONE;
          end
        end
      end
      S_XFER2: if (wait_cnt == 4'd0) state_n = S_DONE;
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // Sequential only when this request lands in the idle cycle right after the previous ready
  assign seq_hit = prev_valid && is_gamepak(dec_region) && (dec_region == acc_region)
                && (cpu_write_en == acc_write) && (cpu_addr[16:0] != 17'd0)
                && (cpu_addr == acc_addr + (cpu_byte ? ADDR_W'(1) : ADDR_W'(4)));

  assign byte_lane = 4'b0001 << cpu_addr[1:0];

  always_comb begin
    first_addr  = {cpu_addr[ADDR_W-1:2], 2'b00};
    first_be    = cpu_byte ? byte_lane : 4'b1111;
    first_wdata = cpu_byte ? {4{cpu_wdata[7:0]}} : cpu_wdata;
    case (dec_width)
      BUS_16: begin
        if (cpu_byte) first_addr = {cpu_addr[ADDR_W-1:1], 1'b0};
        else          first_be   = 4'b0011;
      end
      BUS_8: begin
        first_addr  = cpu_addr;
        first_be    = byte_lane;
        first_wdata = {4{cpu_wdata[7:0]}};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt   <= 4'd0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_be     <= 4'd0;
      mem_wdata  <= '0;
      acc_addr   <= '0;
      acc_write  <= 1'b0;
      acc_byte   <= 1'b0;
      acc_seq    <= 1'b0;
      acc_region <= REG_UNMAPPED;
      acc_width  <= BUS_32;
      lo_cap     <= 1'b0;
      lo_half    <= 16'd0;
      prev_valid <= 1'b0;
    end else begin
      mem_req    <= 1'b0;
      lo_cap     <= load_second;
      prev_valid <= (state == S_DONE);
      // First-half data stays on mem_rdata through the cycle the second strobe is issued
      if (lo_cap) lo_half <= mem_rdata[15:0];
      if (load_first) begin
        acc_addr   <= cpu_addr;
        acc_write  <= cpu_write_en;
        acc_byte   <= cpu_byte;
        acc_seq    <= seq_hit;
        acc_region <= dec_region;
        acc_width  <= dec_width;
        wait_cnt   <= seq_hit ? dec_s : dec_n;
        mem_req    <= (dec_region != REG_UNMAPPED);
        mem_we     <= cpu_write_en;
        mem_addr   <= first_addr;
        mem_be     <= first_be;
        mem_wdata  <= first_wdata;
      end else if (load_second) begin
        wait_cnt <= dec_s;
        mem_req  <= 1'b1;
        mem_addr <= mem_addr + ADDR_W'(2);
        mem_be   <= 4'b1100;
      end else if (wait_cnt != 4'd0) begin
        wait_cnt <= wait_cnt - 4'd1;
      end
    end
  end

  always_comb begin
    cpu_rdata = '0;
    if (state == S_DONE && !acc_write && acc_region != REG_UNMAPPED) begin
      case (acc_width)
        BUS_8:   cpu_rdata = {4{mem_rdata[{acc_addr[1:0], 3'b000} +: 8]}};
        BUS_16:  cpu_rdata = acc_byte ? mem_rdata : {mem_rdata[31:16], lo_half};
        default: cpu_rdata = mem_rdata;
      endcase
    end
  end

  assign cpu_ready  = (state == S_DONE);
  assign access_seq = acc_seq && (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (!reset && state == S_IDLE)
      assert (!(cpu_read_en && cpu_write_en));
  end

endmodule

// File: tb/tb_bus_waitstate_ctrl.sv
// tb/tb_bus_waitstate_ctrl.sv - directed scoreboard bench for bus_waitstate_ctrl
module tb_bus_waitstate_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] cpu_addr;
  logic        cpu_read_en, cpu_write_en, cpu_byte, cpu_instruction_fetch;
  logic [31:0] cpu_wdata, cpu_rdata;
  logic        cpu_ready, access_seq;
  logic [15:0] waitcnt;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic [31:0] mem_rdata = 32'd0;

  bus_waitstate_ctrl #(.ADDR_W(32), .DATA_W(32), .EWRAM_WAIT(2)) dut (
    .clk                   (clk),
    .reset                 (reset),
    .cpu_addr              (cpu_addr),
    .cpu_read_en           (cpu_read_en),
    .cpu_write_en          (cpu_write_en),
    .cpu_wdata             (cpu_wdata),
    .cpu_byte              (cpu_byte),
    .cpu_instruction_fetch (cpu_instruction_fetch),
    .cpu_rdata             (cpu_rdata),
    .cpu_ready             (cpu_ready),
    .access_seq            (access_seq),
    .waitcnt               (waitcnt),
    .mem_req               (mem_req),
    .mem_we                (mem_we),
    .mem_addr              (mem_addr),
    .mem_be                (mem_be),
    .mem_wdata             (mem_wdata),
    .mem_rdata             (mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  be;
    logic        we;
    logic [31:0] wdata;
  } mem_exp_t;

  typedef struct {
    string       tag;
    int          cycle;
    logic [31:0] rdata;
    bit          chk_rdata;
    bit          seq;
  } cpu_exp_t;

  mem_exp_t    mem_q[$];
  cpu_exp_t    cpu_q[$];
  int          n_pass = 0;
  int          n_total = 0;
  logic        mem_override = 1'b0;
  logic [31:0] mem_value = 32'd0;

  // Memory: data for a strobe appears from the following cycle; halves differ per address
  always @(posedge clk)
    if (mem_req)
      mem_rdata <= mem_override ? mem_value
                                : {mem_addr[15:0] ^ 16'hBEEF, mem_addr[15:0] ^ 16'h1234};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  task automatic push_mem(input logic [31:0] addr, input logic [3:0] be, input logic we,
                          input logic [31:0] wdata);
    mem_exp_t m;
    m.addr = addr; m.be = be; m.we = we; m.wdata = wdata;
    mem_q.push_back(m);
  endtask

  task automatic access(input string tag, input logic [31:0] addr, input bit wr, input bit byt,
                        input logic [31:0] wdata, input int exp_cycle, input logic [31:0] exp_rdata,
                        input bit exp_seq, input bit chained);
    cpu_exp_t e;
    cpu_exp_t c;
    mem_exp_t m;
    bit done = 1'b0;
    e.tag = tag; e.cycle = exp_cycle; e.rdata = exp_rdata; e.chk_rdata = !wr; e.seq = exp_seq;
    cpu_q.push_back(e);
    if (!chained) repeat (2) @(negedge clk);
    cpu_addr = addr; cpu_read_en = !wr; cpu_write_en = wr; cpu_byte = byt; cpu_wdata = wdata;
    if (chained) @(posedge clk);
    @(posedge clk);
    for (int k = 0; k < 40 && !done; k++) begin
      @(negedge clk);
      if (k == 0) check({tag, "_seq"}, 32'(access_seq), 32'(exp_seq));
      if (mem_req) begin
        if (mem_q.size() == 0) begin
          check({tag, "_extra_req"}, 32'(mem_req), 32'd0);
        end else begin
          m = mem_q.pop_front();
          check({tag, "_addr"}, mem_addr, m.addr);
          check({tag, "_be"}, 32'(mem_be), 32'(m.be));
          check({tag, "_we"}, 32'(mem_we), 32'(m.we));
          if (m.we) check({tag, "_wdata"}, mem_wdata, m.wdata);
        end
      end
      if (cpu_ready) begin
        c = cpu_q.pop_front();
        check({c.tag, "_cycle"}, 32'(k), 32'(c.cycle));
        if (c.chk_rdata) check({c.tag, "_rdata"}, cpu_rdata, c.rdata);
        done = 1'b1;
      end
    end
    if (!done) begin
      check({tag, "_timeout"}, 32'(cpu_ready), 32'd1);
      if (cpu_q.size() != 0) void'(cpu_q.pop_front());
    end
    check({tag, "_req_left"}, 32'(mem_q.size()), 32'd0);
    mem_q.delete();
    cpu_read_en = 1'b0; cpu_write_en = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    cpu_addr = 32'd0; cpu_read_en = 1'b0; cpu_write_en = 1'b0; cpu_byte = 1'b0;
    cpu_wdata = 32'd0; cpu_instruction_fetch = 1'b0; waitcnt = 16'h0000;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", 32'(cpu_ready), 32'd0);
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_rdata", cpu_rdata, 32'd0);
    check("rst_seq", 32'(access_seq), 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_be", 32'(mem_be), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    reset = 1'b0;

    mem_override = 1'b1; mem_value = 32'h12345678;
    push_mem(32'h03000000, 4'b1111, 1'b0, 32'd0);
    access("iwram_rd", 32'h03000000, 1'b0, 1'b0, 32'd0, 1, 32'h12345678, 1'b0, 1'b0);
    @(negedge clk);
    check("ready_pulse", 32'(cpu_ready), 32'd0);

    push_mem(32'h03000004, 4'b1111, 1'b1, 32'hCAFEF00D);
    access("iwram_wr_misaligned", 32'h03000006, 1'b1, 1'b0, 32'hCAFEF00D, 1, 32'd0, 1'b0, 1'b0);

    access("unmapped", 32'h01000000, 1'b0, 1'b0, 32'd0, 1, 32'd0, 1'b0, 1'b0);

    mem_override = 1'b0; waitcnt = 16'h0000;
    push_mem(32'h08000000, 4'b0011, 1'b0, 32'd0);
    push_mem(32'h08000002, 4'b1100, 1'b0, 32'd0);
    access("rom_nseq", 32'h08000000, 1'b0, 1'b0, 32'd0, 8, 32'hBEED1234, 1'b0, 1'b0);
    push_mem(32'h08000004, 4'b0011, 1'b0, 32'd0);
    push_mem(32'h08000006, 4'b1100, 1'b0, 32'd0);
    access("rom_seq", 32'h08000004, 1'b0, 1'b0, 32'd0, 6, 32'hBEE91230, 1'b1, 1'b1);

    waitcnt = 16'h0014;
    push_mem(32'h0801FFFC, 4'b0011, 1'b0, 32'd0);
    push_mem(32'h0801FFFE, 4'b1100, 1'b0, 32'd0);
    access("rom_pre_bnd", 32'h0801FFFC, 1'b0, 1'b0, 32'd0, 6, 32'h4111EDC8, 1'b0, 1'b0);
    push_mem(32'h08020000, 4'b0011, 1'b0, 32'd0);
    push_mem(32'h08020002, 4'b1100, 1'b0, 32'd0);
    access("rom_bnd", 32'h08020000, 1'b0, 1'b0, 32'd0, 6, 32'hBEED1234, 1'b0, 1'b1);

    push_mem(32'h06000010, 4'b0011, 1'b0, 32'd0);
    push_mem(32'h06000012, 4'b1100, 1'b0, 32'd0);
    access("vram_rd", 32'h06000010, 1'b0, 1'b0, 32'd0, 2, 32'hBEFD1224, 1'b0, 1'b0);

    push_mem(32'h02000002, 4'b1000, 1'b1, 32'hABABABAB);
    access("ewram_wb", 32'h02000003, 1'b1, 1'b1, 32'h000000AB, 3, 32'd0, 1'b0, 1'b0);

    waitcnt = 16'h0060;
    push_mem(32'h0A000004, 4'b0010, 1'b0, 32'd0);
    access("ws1_rdb", 32'h0A000005, 1'b0, 1'b1, 32'd0, 9, 32'hBEEB1230, 1'b0, 1'b0);

    waitcnt = 16'h0003; mem_override = 1'b1; mem_value = 32'h00005A00;
    push_mem(32'h0E000001, 4'b0010, 1'b0, 32'd0);
    access("sram_rd", 32'h0E000001, 1'b0, 1'b0, 32'd0, 9, 32'h5A5A5A5A, 1'b0, 1'b0);
    push_mem(32'h0E000002, 4'b0100, 1'b1, 32'h44444444);
    access("sram_wr", 32'h0E000002, 1'b1, 1'b0, 32'h11223344, 9, 32'd0, 1'b0, 1'b0);

    waitcnt = 16'h0000; mem_override = 1'b0;
    repeat (2) @(negedge clk);
    cpu_addr = 32'h08000000; cpu_read_en = 1'b1; cpu_byte = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("abort_req", 32'(mem_req), 32'd1);
    @(negedge clk);
    reset = 1'b1; cpu_read_en = 1'b0;
    @(negedge clk);
    check("abort_ready", 32'(cpu_ready), 32'd0);
    check("abort_mem_req", 32'(mem_req), 32'd0);
    check("abort_seq", 32'(access_seq), 32'd0);
    reset = 1'b0;
    push_mem(32'h08000004, 4'b0011, 1'b0, 32'd0);
    push_mem(32'h08000006, 4'b1100, 1'b0, 32'd0);
    access("rom_after_rst", 32'h08000004, 1'b0, 1'b0, 32'd0, 8, 32'hBEE91230, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
